// File: rtl/arbiter_round_robin_pkg.sv
// Shared types for the round-robin arbiter: the two operating states
// decoded from the grant register.
package arbiter_round_robin_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arbiter_round_robin_grant_select.sv
// Combinational next-grant pick: rotate priority to bits above the current
// grant, wrapping to the lowest requester when nothing above is asking.
module rr_grant_select #(
  parameter int INPUT_COUNT = 8
) (
  input  logic [INPUT_COUNT-1:0] requests_i,
  input  logic [INPUT_COUNT-1:0] grant_i,
  output logic [INPUT_COUNT-1:0] next_grant_o
);

  localparam logic [INPUT_COUNT-1:0] ONE  = {{(INPUT_COUNT-1){1'b0}}, 1'b1};
  localparam logic [INPUT_COUNT-1:0] ZERO = '0;

  function automatic logic [INPUT_COUNT-1:0] lowest_set(input logic [INPUT_COUNT-1:0] x);
    return x & (~x + ONE);
  endfunction

  logic [INPUT_COUNT-1:0] mask;
  logic [INPUT_COUNT-1:0] masked;

  always_comb begin
    // grant | (grant-1) covers the owner and everything below it
    mask = '1;
    if (grant_i != ZERO) begin
      mask = ~(grant_i | (grant_i - ONE));
    end
    masked = requests_i & mask;
    next_grant_o = (masked != ZERO) ? lowest_set(masked) : lowest_set(requests_i);
  end

endmodule

// File: rtl/arbiter_round_robin.sv
// Registered round-robin arbiter with one-hot grant held until release or
// until the optional hold limit forces rotation while others wait.
module arbiter_round_robin
  import arbiter_round_robin_pkg::*;
#(
  parameter int INPUT_COUNT     = 8,
  parameter int MAX_HOLD_CYCLES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INPUT_COUNT-1:0] requests,
  output logic [INPUT_COUNT-1:0] grant,
  output logic                   grant_changed
);

  localparam bit LIMIT_EN = (MAX_HOLD_CYCLES > 0);
  localparam int HC_W     = LIMIT_EN ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(LIMIT_EN ? MAX_HOLD_CYCLES - 1 : 0);
  localparam logic [INPUT_COUNT-1:0] ZERO = '0;

  logic [INPUT_COUNT-1:0] grant_q, grant_d;
  logic [HC_W-1:0]        hold_q, hold_d;
  logic                   changed_q;
  logic [INPUT_COUNT-1:0] sel_grant;
  arb_state_e             state;
  logic                   owner_req;
  logic                   others_pending;
  logic                   limit_hit;

  rr_grant_select #(
    .INPUT_COUNT(INPUT_COUNT)
  ) u_select (
    .requests_i  (requests),
    .grant_i     (grant_q),
    .next_grant_o(sel_grant)
  );

  always_comb begin
    state          = (grant_q == ZERO) ? ST_IDLE : ST_HELD;
    owner_req      = |(requests & grant_q);
    others_pending = |(requests & ~grant_q);
    limit_hit      = LIMIT_EN && (hold_q == HOLD_LAST);
    grant_d        = grant_q;
    hold_d         = '0;
    case (state)
      ST_IDLE: grant_d = sel_grant;
      ST_HELD: begin
        // Counter parks at the last value when uncontended so a newcomer
        // takes over on its first cycle of asking.
        if (owner_req && !(limit_hit && others_pending)) begin
          hold_d = (!LIMIT_EN || limit_hit) ? hold_q : hold_q + 1'b1;
        end else begin
          grant_d = sel_grant;
        end
      end
      default: grant_d = ZERO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q   <= '0;
      hold_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      changed_q <= (grant_d != grant_q);
    end
  end

  assign grant         = grant_q;
  assign grant_changed = changed_q;

endmodule
